// File: rtl/player_motion_ctrl.sv
// Jump/duck motion controller for a side-scrolling player sprite.
// Define PLAYER_DOUBLE_JUMP_EN to allow one extra jump while airborne.
module player_motion_ctrl #(
  parameter logic [7:0]  GROUND_Y    = 8'd20,
  parameter logic [7:0]  JUMP_HEIGHT = 8'd40,
  parameter logic [7:0]  STEP        = 8'd5,
  parameter logic [25:0] TICK_DIV    = 26'h7A120,
  parameter logic [7:0]  DUCK_TICKS  = 8'd20,
  parameter logic [7:0]  NORM_H      = 8'd16,
  parameter logic [7:0]  DUCK_H      = 8'd8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jump,
  input  logic       duck,
  output logic [7:0] player_y,
  output logic [7:0] player_h,
  output logic       airborne,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2,
    DUCK   = 2'd3
  } state_t;

  localparam logic [7:0]  APEX_BASE = GROUND_Y + JUMP_HEIGHT;
  localparam logic [25:0] TICK_LAST = TICK_DIV - 26'd1;

  state_t      state_reg, state_next;
  logic [7:0]  y_reg, y_next;
  logic [7:0]  duck_cnt_reg, duck_cnt_next;
  logic [7:0]  player_h_reg, player_h_next;
  logic        airborne_reg, airborne_next;
  logic [25:0] div_reg, div_next;
  logic        tick;

  // ---------------- request edge detection ----------------
  logic [1:0] req_in;
  logic [1:0] req_q_reg;
  logic [1:0] req_edge;
  logic       jump_edge, duck_edge;

  assign req_in = {duck, jump};

  // Held-high inputs across reset must not look like fresh requests.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q_reg <= 2'b11;
    end else begin
      req_q_reg <= req_in;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
      assign req_edge[gi] = req_in[gi] & ~req_q_reg[gi];
    end
  endgenerate

  assign jump_edge = req_edge[0];
  assign duck_edge = req_edge[1];

  // ---------------- motion tick divider ----------------
  assign tick     = (div_reg == TICK_LAST);
  assign div_next = tick ? 26'd0 : div_reg + 26'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      div_reg <= 26'd0;
    end else begin
      div_reg <= div_next;
    end
  end

  // ---------------- apex / double jump ----------------
  logic [7:0] apex_cur;
  logic       dj_take;

`ifdef PLAYER_DOUBLE_JUMP_EN
  logic [7:0] apex_reg, apex_next;
  logic       dj_used_reg, dj_used_next;
  logic [8:0] dj_sum;
  logic [7:0] dj_apex;

  assign dj_sum   = {1'b0, y_reg} + {1'b0, JUMP_HEIGHT};
  assign dj_apex  = dj_sum[8] ? 8'hFF : dj_sum[7:0];
  assign apex_cur = apex_reg;
  assign dj_take  = jump_edge & ~dj_used_reg &
                    ((state_reg == RISE) || (state_reg == FALL));

  always_ff @(posedge clock) begin
    if (reset) begin
      apex_reg    <= APEX_BASE;
      dj_used_reg <= 1'b0;
    end else begin
      apex_reg    <= apex_next;
      dj_used_reg <= dj_used_next;
    end
  end

  always_comb begin
    apex_next    = apex_reg;
    dj_used_next = dj_used_reg;
    if (state_reg == GROUND && jump_edge) begin
      apex_next = APEX_BASE;
    end else if (dj_take) begin
      apex_next    = dj_apex;
      dj_used_next = 1'b1;
    end
    if (state_next == GROUND) begin
      dj_used_next = 1'b0;
    end
  end
`else
  assign apex_cur = APEX_BASE;
  assign dj_take  = 1'b0;
`endif

  // ---------------- y arithmetic ----------------
  logic [8:0] rise_sum;
  logic       rise_hit;
  logic [7:0] fall_gap;
  logic       fall_hit;

  assign rise_sum = {1'b0, y_reg} + {1'b0, STEP};
  assign rise_hit = (rise_sum >= {1'b0, apex_cur});
  // y never drops below GROUND_Y, so this difference cannot wrap.
  assign fall_gap = y_reg - GROUND_Y;
  assign fall_hit = (fall_gap <= STEP);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= GROUND;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      GROUND: begin
        if (jump_edge) begin
          state_next = RISE;
        end else if (duck_edge) begin
          state_next = DUCK;
        end
      end
      RISE: begin
        if (dj_take) begin
          state_next = RISE;
        end else if (tick && rise_hit) begin
          state_next = FALL;
        end
      end
      FALL: begin
        if (dj_take) begin
          state_next = RISE;
        end else if (tick && fall_hit) begin
          state_next = GROUND;
        end
      end
      DUCK: begin
        if (tick && duck_cnt_reg == 8'd1) begin
          state_next = GROUND;
        end
      end
      default: state_next = GROUND;
    endcase
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    y_next        = y_reg;
    duck_cnt_next = duck_cnt_reg;
    case (state_reg)
      GROUND: begin
        if (!jump_edge && duck_edge) begin
          duck_cnt_next = DUCK_TICKS;
        end
      end
      RISE: begin
        if (!dj_take && tick) begin
          y_next = rise_hit ? apex_cur : rise_sum[7:0];
        end
      end
      FALL: begin
        if (!dj_take && tick) begin
          y_next = fall_hit ? GROUND_Y : y_reg - STEP;
        end
      end
      DUCK: begin
        y_next = GROUND_Y;
        if (tick) begin
          duck_cnt_next = duck_cnt_reg - 8'd1;
        end
      end
      default: y_next = GROUND_Y;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    player_h_next = NORM_H;
    airborne_next = 1'b0;
    case (state_next)
      DUCK:       player_h_next = DUCK_H;
      RISE, FALL: airborne_next = 1'b1;
      default:    begin
        player_h_next = NORM_H;
        airborne_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      y_reg        <= GROUND_Y;
      duck_cnt_reg <= 8'd0;
      player_h_reg <= NORM_H;
      airborne_reg <= 1'b0;
    end else begin
      y_reg        <= y_next;
      duck_cnt_reg <= duck_cnt_next;
      player_h_reg <= player_h_next;
      airborne_reg <= airborne_next;
    end
  end

  assign player_y = y_reg;
  assign player_h = player_h_reg;
  assign airborne = airborne_reg;
  assign state    = state_reg;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl with TICK_DIV=4 (STEP=5 and STEP=7 instances).
module tb_player_motion_ctrl;

  logic       clock;
  logic       reset;
  logic       jump, duck, jump7, duck7;
  logic [7:0] y, h, y7, h7;
  logic       air, air7;
  logic [1:0] st, st7;

  int checks   = 0;
  int failures = 0;

  player_motion_ctrl #(.TICK_DIV(26'd4)) dut (
    .clock(clock), .reset(reset), .jump(jump), .duck(duck),
    .player_y(y), .player_h(h), .airborne(air), .state(st)
  );

  player_motion_ctrl #(.TICK_DIV(26'd4), .STEP(8'd7)) dut7 (
    .clock(clock), .reset(reset), .jump(jump7), .duck(duck7),
    .player_y(y7), .player_h(h7), .airborne(air7), .state(st7)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Waits (bounded) for the selected instance's y to move away from prev.
  task automatic wait_y(input int sel, input logic [7:0] prev, output logic [7:0] v);
    v = prev;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      v = (sel == 7) ? y7 : y;
      if (v != prev) break;
    end
  endtask

  task automatic pulse_jump();
    jump = 1'b1;
    @(negedge clock);
    jump = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    int rise7[6] = '{27, 34, 41, 48, 55, 60};
    int fall7[6] = '{53, 46, 39, 32, 25, 20};

    reset = 1'b1; jump = 1'b1; duck = 1'b0; jump7 = 1'b0; duck7 = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_state", st, 0);
    check("rst_y", y, 20);
    check("rst_h", h, 16);
    check("rst_air", air, 0);
    check("rst7_y", y7, 20);

    // jump held high through reset must not start a jump
    repeat (10) @(negedge clock);
    check("held_jump_state", st, 0);
    check("held_jump_y", y, 20);
    jump = 1'b0;
    @(negedge clock);
    pulse_jump();
    check("jump_rise_state", st, 1);
    check("jump_rise_air", air, 1);

    v = 8'd20;
    for (int k = 1; k <= 8; k++) begin
      wait_y(0, v, v);
      check($sformatf("rise_y%0d", k), v, 20 + 5 * k);
      check($sformatf("rise_st%0d", k), st, (k == 8) ? 2 : 1);
    end
    for (int k = 1; k <= 8; k++) begin
      wait_y(0, v, v);
      check($sformatf("fall_y%0d", k), v, 60 - 5 * k);
      check($sformatf("fall_st%0d", k), st, (k == 8) ? 0 : 2);
    end
    check("land_air", air, 0);

    // STEP=7 clamps at both ends
    jump7 = 1'b1;
    @(negedge clock);
    jump7 = 1'b0;
    check("s7_state", st7, 1);
    v = 8'd20;
    for (int k = 0; k < 6; k++) begin
      wait_y(7, v, v);
      check($sformatf("s7_rise_y%0d", k), v, rise7[k]);
    end
    check("s7_apex_state", st7, 2);
    for (int k = 0; k < 6; k++) begin
      wait_y(7, v, v);
      check($sformatf("s7_fall_y%0d", k), v, fall7[k]);
    end
    check("s7_land_state", st7, 0);

    // duck: 20 ticks, jump mid-duck ignored
    repeat (3) @(negedge clock);
    duck = 1'b1;
    @(negedge clock);
    duck = 1'b0;
    check("duck_state", st, 3);
    check("duck_h", h, 8);
    repeat (10) @(negedge clock);
    pulse_jump();
    check("duck_jump_ignored", st, 3);
    check("duck_y", y, 20);
    repeat (65) @(negedge clock);
    check("duck_still_76", st, 3);
    check("duck_h_76", h, 8);
    repeat (4) @(negedge clock);
    check("duck_end_state", st, 0);
    check("duck_end_h", h, 16);
    repeat (8) @(negedge clock);
    check("duck_no_queue", st, 0);

    // airborne jump: double jump only when enabled
    pulse_jump();
    v = 8'd20;
    for (int k = 1; k <= 12; k++) wait_y(0, v, v);
    check("dj_fall_y", v, 40);
    check("dj_fall_st", st, 2);
    pulse_jump();
`ifdef PLAYER_DOUBLE_JUMP_EN
    check("dj_state", st, 1);
    for (int k = 1; k <= 8; k++) begin
      wait_y(0, v, v);
      check($sformatf("dj_rise_y%0d", k), v, 40 + 5 * k);
      if (k == 2) begin
        pulse_jump();
        check("dj_third_ignored", st, 1);
      end
    end
    check("dj_apex_state", st, 2);
    for (int k = 1; k <= 12; k++) wait_y(0, v, v);
    check("dj_land_y", v, 20);
    check("dj_land_state", st, 0);
`else
    check("nodj_state", st, 2);
    for (int k = 1; k <= 4; k++) begin
      wait_y(0, v, v);
      check($sformatf("nodj_fall_y%0d", k), v, 40 - 5 * k);
    end
    check("nodj_land_state", st, 0);
`endif

    // simultaneous jump+duck: jump wins; then reset mid-jump
    repeat (3) @(negedge clock);
    jump = 1'b1; duck = 1'b1;
    @(negedge clock);
    jump = 1'b0; duck = 1'b0;
    check("both_state", st, 1);
    check("both_h", h, 16);
    v = 8'd20;
    for (int k = 1; k <= 5; k++) wait_y(0, v, v);
    check("pre_reset_y", v, 45);
    reset = 1'b1;
    @(negedge clock);
    check("abort_y", y, 20);
    check("abort_state", st, 0);
    check("abort_air", air, 0);
    reset = 1'b0;
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
